// File: rtl/tone_scheduler.sv
// tone_scheduler: queues timed note events in a small FIFO and plays them
// back-to-back, driving the tone divider's div_num and the output gate.
// Durations and articulation gaps are counted in external tick strobes.
module tone_scheduler #(
    parameter int N         = 11,
    parameter int DUR_W     = 16,
    parameter int GAP_TICKS = 0,
    parameter int DEPTH     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [N-1:0]     req_div,
    input  logic [DUR_W-1:0] req_dur,
    input  logic             req_rest,
    input  logic             tick,
    input  logic             abort,
    output logic [N-1:0]     div_num,
    output logic             gate,
    output logic             done,
    output logic             busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // Gap counter only needs to hold GAP_TICKS; keep at least one bit so the
    // GAP_TICKS == 0 build still elaborates cleanly.
    localparam int GAP_W = (GAP_TICKS < 2) ? 1 : $clog2(GAP_TICKS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    // FIFO storage; the head entry is read asynchronously because the IDLE
    // state loads it on the same edge that pops it.
    logic [N-1:0]     mem_div  [DEPTH];
    logic [DUR_W-1:0] mem_dur  [DEPTH];
    logic             mem_rest [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    logic [1:0]       state_reg;
    logic [DUR_W-1:0] remaining_reg;
    logic [GAP_W-1:0] gap_cnt_reg;
    logic [N-1:0]     div_num_reg;
    logic             gate_reg;
    logic             done_reg;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [N-1:0]     head_div;
    logic [DUR_W-1:0] head_dur;
    logic             head_rest;

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);

    // Ready deliberately ignores a same-cycle pop so it depends only on
    // registered state plus the abort/reset controls.
    assign req_ready = !full && !abort && !rst;
    assign push      = req_valid && req_ready;
    assign pop       = (state_reg == S_IDLE) && !empty && !abort && !rst;

    assign head_div  = mem_div[rd_ptr_reg];
    assign head_dur  = mem_dur[rd_ptr_reg];
    assign head_rest = mem_rest[rd_ptr_reg];

    assign div_num = div_num_reg;
    assign gate    = gate_reg;
    assign done    = done_reg;
    assign busy    = (state_reg != S_IDLE) || !empty;

    // Next occupancy: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    // Write accepted requests into the slot addressed by the write pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_div[wr_ptr_reg]  <= req_div;
            mem_dur[wr_ptr_reg]  <= req_dur;
            mem_rest[wr_ptr_reg] <= req_rest;
        end
    end

    // FIFO pointers and occupancy; abort flushes just like reset.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

    // Note playback state machine: load in IDLE, count ticks in PLAY/GAP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            remaining_reg <= '0;
            gap_cnt_reg   <= '0;
            div_num_reg   <= '0;
            gate_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else if (abort) begin
            // Silence immediately; div_num is left alone so the divider does
            // not see a spurious ratio change.
            state_reg <= S_IDLE;
            gate_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    gate_reg <= 1'b0;
                    if (pop) begin
                        if (head_dur == '0) begin
                            // Zero-length event: consumed and acknowledged only.
                            done_reg <= 1'b1;
                        end else begin
                            div_num_reg   <= head_div;
                            remaining_reg <= head_dur;
                            gate_reg      <= !head_rest;
                            state_reg     <= S_PLAY;
                        end
                    end
                end
                S_PLAY: begin
                    if (tick) begin
                        // remaining is at least 1 here, so this never wraps.
                        remaining_reg <= remaining_reg - DUR_W'(1);
                        if (remaining_reg == DUR_W'(1)) begin
                            gate_reg <= 1'b0;
                            if (GAP_TICKS == 0) begin
                                done_reg  <= 1'b1;
                                state_reg <= S_IDLE;
                            end else begin
                                gap_cnt_reg <= GAP_W'(GAP_TICKS);
                                state_reg   <= S_GAP;
                            end
                        end
                    end
                end
                S_GAP: begin
                    gate_reg <= 1'b0;
                    if (tick) begin
                        gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
                        if (gap_cnt_reg == GAP_W'(1)) begin
                            done_reg  <= 1'b1;
                            state_reg <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    gate_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule
